// File: rtl/conv_sequencer_if.sv
// Bundle of the sequencer's command, issue and retire signals.
// master: pipeline controller / testbench side (drives commands and retire returns).
// slave:  conv_sequencer side (drives issue outputs and status).
//   start, abort, stall      : commands and sink backpressure
//   res_valid, res_last      : retire return from the add stage
//   row, col, addr, enable,
//   endSign                  : issue to the register-fetch stage
//   busy, done, res_count    : pass status
interface conv_sequencer_if;
  logic       start;
  logic       abort;
  logic       stall;
  logic       res_valid;
  logic       res_last;
  logic [4:0] row;
  logic [4:0] col;
  logic [1:0] addr;
  logic       enable;
  logic       endSign;
  logic       busy;
  logic       done;
  logic [9:0] res_count;

  modport master (
    output start, abort, stall, res_valid, res_last,
    input  row, col, addr, enable, endSign, busy, done, res_count
  );

  modport slave (
    input  start, abort, stall, res_valid, res_last,
    output row, col, addr, enable, endSign, busy, done, res_count
  );
endinterface

// File: rtl/conv_sequencer.sv
// Pipeline-head sequencer for the convolution datapath. A start command scans every KxK window
// of an IMG_H x IMG_W image, issuing one kernel row per unstalled cycle (addr fastest, then col,
// then row). Retired windows returning from the add stage are counted; done pulses once all
// windows have retired.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : conv_sequencer_if.slave (commands, issue outputs, retire inputs, status)
module conv_sequencer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned K     = 3
) (
  input  logic             clk,
  input  logic             rst,
  conv_sequencer_if.slave  bus
);

  localparam int unsigned OutW  = IMG_W - K + 1;
  localparam int unsigned OutH  = IMG_H - K + 1;
  localparam int unsigned Total = OutW * OutH;

  localparam logic [4:0] LastCol  = 5'(OutW - 1);
  localparam logic [4:0] LastRow  = 5'(OutH - 1);
  localparam logic [1:0] LastAddr = 2'(K - 1);
  localparam logic [9:0] TotalCnt = 10'(Total);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e     state_q;
  // Issued (output) coordinates and the coordinates of the next issue are kept separately so the
  // outputs can hold their last values through stalls, DRAIN and IDLE.
  logic [4:0] row_q, col_q, nxt_row_q, nxt_col_q;
  logic [1:0] addr_q, nxt_addr_q;
  logic       enable_q, end_q, busy_q, done_q;
  logic [9:0] res_count_q, res_count_d;
  logic       retire;
  logic       last_issue;

  always_comb begin
    retire      = (state_q != StIdle) && bus.res_valid && bus.res_last;
    res_count_d = res_count_q + {9'd0, retire};
    last_issue  = (nxt_row_q == LastRow) && (nxt_col_q == LastCol) && (nxt_addr_q == LastAddr);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      nxt_row_q   <= '0;
      nxt_col_q   <= '0;
      nxt_addr_q  <= '0;
      enable_q    <= 1'b0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_count_q <= '0;
    end else begin
      res_count_q <= res_count_d;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            res_count_q <= '0;
            nxt_row_q   <= '0;
            nxt_col_q   <= '0;
            nxt_addr_q  <= '0;
          end
        end
        StRun: begin
          if (bus.stall) begin
            enable_q <= 1'b0;
            end_q    <= 1'b0;
          end else begin
            enable_q <= 1'b1;
            end_q    <= (nxt_addr_q == LastAddr);
            row_q    <= nxt_row_q;
            col_q    <= nxt_col_q;
            addr_q   <= nxt_addr_q;
            if (last_issue) begin
              // Next-issue counters freeze on the final window so nothing can wrap.
              state_q <= StDrain;
            end else if (nxt_addr_q != LastAddr) begin
              nxt_addr_q <= nxt_addr_q + 2'd1;
            end else begin
              nxt_addr_q <= '0;
              if (nxt_col_q != LastCol) begin
                nxt_col_q <= nxt_col_q + 5'd1;
              end else begin
                nxt_col_q <= '0;
                nxt_row_q <= nxt_row_q + 5'd1;
              end
            end
          end
        end
        StDrain: begin
          enable_q <= 1'b0;
          end_q    <= 1'b0;
          // Include this cycle's retire so done is not delayed a cycle.
          if (res_count_d >= TotalCnt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.addr      = addr_q;
  assign bus.enable    = enable_q;
  assign bus.endSign   = end_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_count = res_count_q;

endmodule
